// File: rtl/mips_pkg.sv
// Shared constants and occupancy encoding for the MIPS inter-stage buffers.
package mips_pkg;
  localparam int          PC_W_DEF   = 32;
  localparam int          DATA_W_DEF = 32;
  localparam logic [31:0] MIPS_NOP   = 32'h0000_0000; // sll $0,$0,0

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;
endpackage

// File: rtl/pipe_slot.sv
// W-bit storage register with load enable and async active-low reset to RST_VAL.
module pipe_slot #(
  parameter int             W       = 32,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] val_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) val_q <= RST_VAL;
    else if (load_i) val_q <= d_i;
  end

  assign q_o = val_q;
endmodule

// File: rtl/pipe_stage_buffer.sv
// Inter-stage pipeline register carrying {pc, instr} with valid/ready handshake,
// optional 2-entry skid, synchronous flush, NOP bubbles and a saturating stall counter.
module pipe_stage_buffer
  import mips_pkg::*;
#(
  parameter int                PC_W     = PC_W_DEF,
  parameter int                DATA_W   = DATA_W_DEF,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(MIPS_NOP),
  parameter bit                SKID     = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   pc_out,
  output logic [DATA_W-1:0] data_out,
  output logic [15:0]       stall_cnt
);
  occ_e              state_q, state_d;
  logic              load_m, load_s, m_from_s;
  logic              in_xfer, out_xfer;
  logic [PC_W-1:0]   m_pc_q, s_pc_q, m_pc_d;
  logic [DATA_W-1:0] m_data_q, s_data_q, m_data_d;
  logic [15:0]       stall_q, stall_d;

  // Without the skid entry a full buffer can only accept while it is draining.
  assign in_ready  = SKID ? (state_q != OCC_TWO) : ((state_q == OCC_EMPTY) || out_ready);
  assign out_valid = (state_q != OCC_EMPTY);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_comb begin
    state_d  = state_q;
    load_m   = 1'b0;
    load_s   = 1'b0;
    m_from_s = 1'b0;
    if (flush) begin
      state_d = OCC_EMPTY;
    end else begin
      case (state_q)
        OCC_EMPTY: if (in_xfer) begin
          state_d = OCC_ONE;
          load_m  = 1'b1;
        end
        OCC_ONE: begin
          if (in_xfer && out_xfer) begin
            load_m = 1'b1;
          end else if (in_xfer) begin
            state_d = OCC_TWO;
            load_s  = 1'b1;
          end else if (out_xfer) begin
            state_d = OCC_EMPTY;
          end
        end
        OCC_TWO: if (out_xfer) begin
          state_d  = OCC_ONE;
          load_m   = 1'b1;
          m_from_s = 1'b1;
        end
        default: state_d = OCC_EMPTY;
      endcase
    end
  end

  assign m_pc_d   = m_from_s ? s_pc_q   : pc_in;
  assign m_data_d = m_from_s ? s_data_q : data_in;
  assign stall_d  = (out_valid && !out_ready && (stall_q != 16'hFFFF)) ? stall_q + 16'd1 : stall_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= OCC_EMPTY;
      stall_q <= 16'd0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
    end
  end

  pipe_slot #(.W(PC_W),   .RST_VAL('0))       u_m_pc   (.clk_i(clock), .rst_ni(reset), .load_i(load_m), .d_i(m_pc_d),   .q_o(m_pc_q));
  pipe_slot #(.W(DATA_W), .RST_VAL(NOP_WORD)) u_m_data (.clk_i(clock), .rst_ni(reset), .load_i(load_m), .d_i(m_data_d), .q_o(m_data_q));
  pipe_slot #(.W(PC_W),   .RST_VAL('0))       u_s_pc   (.clk_i(clock), .rst_ni(reset), .load_i(load_s), .d_i(pc_in),    .q_o(s_pc_q));
  pipe_slot #(.W(DATA_W), .RST_VAL(NOP_WORD)) u_s_data (.clk_i(clock), .rst_ni(reset), .load_i(load_s), .d_i(data_in),  .q_o(s_data_q));

  // Bubble whenever nothing valid is held so stale words never leak downstream.
  assign pc_out    = out_valid ? m_pc_q   : '0;
  assign data_out  = out_valid ? m_data_q : NOP_WORD;
  assign stall_cnt = stall_q;
endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Scoreboard bench for pipe_stage_buffer: skid (SKID=1) and single-entry (SKID=0) instances.
module tb_pipe_stage_buffer;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] pc_in = '0, data_in = '0;
  logic        iv_s = 1'b0, ordy_s = 1'b1, iv_n = 1'b0, ordy_n = 1'b1;
  logic        ir_s, ov_s, ir_n, ov_n;
  logic [31:0] pco_s, dato_s, pco_n, dato_n;
  logic [15:0] sc_s, sc_n;

  ent_t        sb[$];
  logic [15:0] st_model[2];
  int          n_checks = 0;
  int          n_errors = 0;
  bit          last_xin;

  always #5 clock = ~clock;

  pipe_stage_buffer #(.SKID(1'b1)) dut_s (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(iv_s), .in_ready(ir_s), .pc_in(pc_in), .data_in(data_in),
    .out_valid(ov_s), .out_ready(ordy_s), .pc_out(pco_s), .data_out(dato_s),
    .stall_cnt(sc_s));

  pipe_stage_buffer #(.SKID(1'b0)) dut_n (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(iv_n), .in_ready(ir_n), .pc_in(pc_in), .data_in(data_in),
    .out_valid(ov_n), .out_ready(ordy_n), .pc_out(pco_n), .data_out(dato_n),
    .stall_cnt(sc_n));

  // One clock of stimulus on the selected instance (sel=0 skid, sel=1 no-skid), checked at negedge.
  task automatic cycle(input bit sel, input bit iv, input logic [31:0] pc, input logic [31:0] dat,
                       input bit ordy, input bit fl);
    logic        o_v, o_r, exp_v, exp_r, xin, xout;
    logic [31:0] o_pc, o_dat;
    logic [15:0] o_sc;
    ent_t        e;
    if (!sel) begin iv_s = iv; ordy_s = ordy; iv_n = 1'b0; ordy_n = 1'b1; end
    else      begin iv_n = iv; ordy_n = ordy; iv_s = 1'b0; ordy_s = 1'b1; end
    pc_in = pc; data_in = dat; flush = fl;
    @(negedge clock);
    o_v   = sel ? ov_n   : ov_s;
    o_r   = sel ? ir_n   : ir_s;
    o_pc  = sel ? pco_n  : pco_s;
    o_dat = sel ? dato_n : dato_s;
    o_sc  = sel ? sc_n   : sc_s;
    exp_v = (sb.size() != 0);
    exp_r = sel ? ((sb.size() == 0) || ordy) : (sb.size() < 2);
    n_checks++;
    if (o_v !== exp_v) begin n_errors++; $display("FAIL out_valid: got %b expected %b", o_v, exp_v); end
    n_checks++;
    if (o_r !== exp_r) begin n_errors++; $display("FAIL in_ready: got %b expected %b", o_r, exp_r); end
    n_checks++;
    if (o_sc !== st_model[sel]) begin n_errors++; $display("FAIL stall_cnt: got %h expected %h", o_sc, st_model[sel]); end
    if (!exp_v) begin
      n_checks++;
      if (o_pc !== 32'h0 || o_dat !== 32'h0) begin
        n_errors++; $display("FAIL bubble: got pc=%h data=%h expected pc=0 data=0", o_pc, o_dat);
      end
    end
    xin  = iv && exp_r;
    xout = exp_v && ordy;
    last_xin = xin;
    if (xout) begin
      e = sb.pop_front();
      n_checks++;
      if (o_pc !== e.pc || o_dat !== e.data) begin
        n_errors++; $display("FAIL out_word: got pc=%h data=%h expected pc=%h data=%h", o_pc, o_dat, e.pc, e.data);
      end
    end
    if (fl) sb.delete();
    else if (xin) sb.push_back('{pc: pc, data: dat});
    if (exp_v && !ordy && st_model[sel] != 16'hFFFF) st_model[sel] = st_model[sel] + 16'd1;
    @(posedge clock); #1;
  endtask

  task automatic drain(input bit sel);
    for (int i = 0; i < 4; i++) cycle(sel, 1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_reset;
    #2;
    n_checks++;
    if (ov_s !== 1'b0 || ir_s !== 1'b1 || pco_s !== 32'h0 || dato_s !== 32'h0 || sc_s !== 16'h0) begin
      n_errors++; $display("FAIL reset_state: got v=%b r=%b pc=%h d=%h sc=%h expected 0 1 0 0 0", ov_s, ir_s, pco_s, dato_s, sc_s);
    end
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_stream;
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 32'(i * 4), 32'h2000_0000 + 32'(i), 1'b1, 1'b0);
    drain(1'b0);
  endtask

  task automatic test_reset_mid;
    cycle(1'b0, 1'b1, 32'h40, 32'hDEAD_0001, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'h44, 32'hDEAD_0002, 1'b0, 1'b0);
    iv_s = 1'b0;
    reset = 1'b0;
    #1;
    n_checks++;
    if (ov_s !== 1'b0 || dato_s !== 32'h0 || ir_s !== 1'b1 || pco_s !== 32'h0 || sc_s !== 16'h0) begin
      n_errors++; $display("FAIL reset_mid: got v=%b d=%h r=%b pc=%h sc=%h expected 0 0 1 0 0", ov_s, dato_s, ir_s, pco_s, sc_s);
    end
    sb.delete();
    st_model[0] = '0; st_model[1] = '0;
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    drain(1'b0);
  endtask

  task automatic test_stall;
    cycle(1'b0, 1'b1, 32'h100, 32'hAAAA_0000, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'h104, 32'hBBBB_0000, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'h108, 32'hCCCC_0000, 1'b0, 1'b0);
    n_checks++;
    if (last_xin !== 1'b0 || ir_s !== 1'b0) begin
      n_errors++; $display("FAIL stall_ready_c: got %b expected 0", ir_s);
    end
    cycle(1'b0, 1'b1, 32'h108, 32'hCCCC_0000, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'h108, 32'hCCCC_0000, 1'b0, 1'b0);
    n_checks++;
    if (sc_s !== 16'd4) begin n_errors++; $display("FAIL stall_count4: got %0d expected 4", sc_s); end
    cycle(1'b0, 1'b1, 32'h108, 32'hCCCC_0000, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 32'h108, 32'hCCCC_0000, 1'b1, 1'b0);
    drain(1'b0);
  endtask

  task automatic test_flush;
    cycle(1'b0, 1'b1, 32'h200, 32'hEEEE_0000, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'h204, 32'hFFFF_0000, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'h208, 32'hD0D0_D0D0, 1'b0, 1'b1);
    n_checks++;
    if (ov_s !== 1'b0 || dato_s !== 32'h0 || sc_s !== 16'd6) begin
      n_errors++; $display("FAIL flush_two: got v=%b d=%h sc=%0d expected 0 0 6", ov_s, dato_s, sc_s);
    end
    drain(1'b0);
    cycle(1'b0, 1'b1, 32'h300, 32'h1234_5678, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 32'h304, 32'h9999_9999, 1'b1, 1'b1);
    drain(1'b0);
  endtask

  task automatic test_noskid;
    int acc;
    cycle(1'b1, 1'b1, 32'h400, 32'hAAAA_1111, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 32'h404, 32'hBBBB_2222, 1'b0, 1'b0);
    n_checks++;
    if (last_xin !== 1'b0 || ir_n !== 1'b0) begin
      n_errors++; $display("FAIL noskid_full: got in_ready=%b expected 0", ir_n);
    end
    cycle(1'b1, 1'b1, 32'h404, 32'hBBBB_2222, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 32'h404, 32'hBBBB_2222, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 32'h408, 32'hCCCC_3333, 1'b1, 1'b0);
    drain(1'b1);
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b1, 32'h500 + 32'(i * 4), 32'h5000_0000 + 32'(i), 1'b1, 1'b0);
      if (last_xin) acc++;
    end
    n_checks++;
    if (acc != 8) begin n_errors++; $display("FAIL noskid_tput: got %0d expected 8", acc); end
    drain(1'b1);
  endtask

  task automatic test_saturation;
    cycle(1'b0, 1'b1, 32'h600, 32'h6666_6666, 1'b0, 1'b0);
    iv_s = 1'b0; ordy_s = 1'b0;
    repeat (65600) @(posedge clock);
    #1;
    st_model[0] = 16'hFFFF;
    @(negedge clock);
    n_checks++;
    if (sc_s !== 16'hFFFF) begin n_errors++; $display("FAIL stall_sat: got %h expected ffff", sc_s); end
    @(posedge clock); #1;
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    drain(1'b0);
  endtask

  initial begin
    st_model[0] = '0; st_model[1] = '0;
    test_reset();
    test_stream();
    test_reset_mid();
    test_stall();
    test_flush();
    test_noskid();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
